// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, default bus widths and opcodes.
package cpu_pkg;

    localparam int BUS_WIDTH_DEF = 16;
    localparam int PC_WIDTH_DEF  = 8;

    localparam logic [3:0] OPC_NOP = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between fetch_unit and its neighbours: control-unit strobes, instruction
// memory handshake and the fetched instruction / status outputs.
interface fetch_unit_if import cpu_pkg::*; #(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int PC_WIDTH  = PC_WIDTH_DEF
);

    logic                 imem_read;
    logic                 pc_inc;
    logic                 jump;
    logic [PC_WIDTH-1:0]  jump_addr;
    logic [BUS_WIDTH-1:0] imem_rdata;
    logic                 imem_ack;

    logic                 imem_req;
    logic [PC_WIDTH-1:0]  imem_addr;
    logic [BUS_WIDTH-1:0] ir;
    logic                 ir_valid;
    logic [PC_WIDTH-1:0]  pc;
    logic                 busy;
    logic                 fetch_err;

    // Control unit and memory side
    modport master (
        output imem_read, pc_inc, jump, jump_addr, imem_rdata, imem_ack,
        input  imem_req, imem_addr, ir, ir_valid, pc, busy, fetch_err
    );

    // Fetch unit side
    modport slave (
        input  imem_read, pc_inc, jump, jump_addr, imem_rdata, imem_ack,
        output imem_req, imem_addr, ir, ir_valid, pc, busy, fetch_err
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: jump load has priority over increment; increment wraps silently.
module pc_reg #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jump,
    input  logic                pc_inc,
    input  logic [PC_WIDTH-1:0] jump_addr,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= '0;
        end else if (jump) begin
            pc <= jump_addr;
        end else if (pc_inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time with an ack timeout,
// instruction register with a one-cycle valid pulse, and the program counter.
module fetch_unit import cpu_pkg::*; #(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int PC_WIDTH  = PC_WIDTH_DEF,
    parameter int TIMEOUT   = 8
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.slave bus
);

    localparam logic [3:0]           TIMEOUT_CNT = 4'(TIMEOUT);
    localparam logic [BUS_WIDTH-1:0] IR_NOP      = {OPC_NOP, {(BUS_WIDTH-4){1'b0}}};

    fetch_state_e         state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  addr_q;
    logic [BUS_WIDTH-1:0] ir_q;
    logic                 ir_valid_q;
    logic                 err_q;
    logic                 addr_load;
    logic                 ir_load;
    logic                 err_set;

    pc_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .jump      (bus.jump),
        .pc_inc    (bus.pc_inc),
        .jump_addr (bus.jump_addr),
        .pc        (pc_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Strobes arriving in a state that cannot use them fall through the defaults
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_load = 1'b0;
        ir_load   = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.imem_read) begin
                    addr_load = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt_nxt == TIMEOUT_CNT) begin
                        err_set   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address is captured from the pre-update pc so a same-cycle jump/inc cannot move it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            ir_q       <= IR_NOP;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ir_valid_q <= ir_load;
            if (addr_load) begin
                addr_q <= pc_q;
            end
            if (ir_load) begin
                ir_q  <= bus.imem_rdata;
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.imem_req  = (state != ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.imem_addr = addr_q;
    assign bus.ir        = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.pc        = pc_q;
    assign bus.fetch_err = err_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter BUS_WIDTH, default 16: instruction/IR width.
REQ-002 Parameter PC_WIDTH, default 8: program counter and instruction-memory address width.
REQ-003 Parameter TIMEOUT, default 8: maximum cycles to wait for imem_ack; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_read  input  1  fetch request strobe from the control unit.
REQ-007 pc_inc  input  1  increment-PC strobe from the control unit.
REQ-008 jump  input  1  load-PC strobe from the control unit.
REQ-009 jump_addr  input  PC_WIDTH  PC load value, used when jump=1.
REQ-010 imem_rdata  input  BUS_WIDTH  instruction-memory read data, valid when imem_ack=1.
REQ-011 imem_ack  input  1  instruction-memory completion, one cycle per request.
REQ-012 imem_req  output  1  memory request, held until ack or timeout.
REQ-013 imem_addr  output  PC_WIDTH  memory address, stable while imem_req=1.
REQ-014 ir  output  BUS_WIDTH  instruction register feeding the control unit.
REQ-015 ir_valid  output  1  one-cycle pulse: ir updated this cycle.
REQ-016 pc  output  PC_WIDTH  current program counter.
REQ-017 busy  output  1  high in REQ and WAIT.
REQ-018 fetch_err  output  1  sticky timeout flag.

Function
REQ-019 FSM states IDLE, REQ, WAIT; encodings come from the shared package.
REQ-020 IDLE: imem_read=1 -> REQ; the fetch address is latched from the pre-update pc of that cycle.
REQ-021 REQ: imem_req=1, imem_addr=latched address, timeout counter cleared; next state WAIT.
REQ-022 WAIT: imem_req stays 1; imem_ack=1 -> ir<=imem_rdata, ir_valid=1 on the next cycle, fetch_err cleared, -> IDLE.
REQ-023 WAIT: the counter increments each cycle without ack; when it reaches TIMEOUT, -> IDLE, fetch_err set, ir unchanged, no ir_valid.
REQ-024 An imem_ack in IDLE or REQ is ignored.
REQ-025 An imem_read in REQ or WAIT is ignored; requests are not queued.
REQ-026 PC update runs in every state: jump=1 -> pc<=jump_addr; else pc_inc=1 -> pc<=pc+1; else hold.
REQ-027 jump has priority over a simultaneous pc_inc.
REQ-028 pc+1 wraps from 2^PC_WIDTH-1 to 0 with no flag.
REQ-029 A PC change during REQ/WAIT does not alter imem_addr of the outstanding fetch.
REQ-030 Fetch latency, imem_read to ir_valid: 3 cycles with a same-cycle ack in WAIT, plus one per wait cycle.
REQ-031 ir holds its value between fetches.

Reset
REQ-032 Reset asserted -> immediately: state IDLE, pc=0, ir=0, ir_valid=0, imem_req=0, imem_addr=0, busy=0, fetch_err=0, counter=0.
REQ-033 Reset during REQ/WAIT abandons the fetch; a late imem_ack after reset release is ignored (REQ-024).

Structure
REQ-034 Package cpu_pkg holds the FSM state typedef, BUS_WIDTH/PC_WIDTH defaults and the NOP opcode constant (4'h0).
REQ-035 Sub-module pc_reg (PC register with jump/increment priority) is instantiated once; the FSM, counter and IR live in fetch_unit.

Verification
REQ-036 Reset, imem_read at pc=0, memory acks in the first WAIT cycle with 16'h1234 -> imem_addr=0, ir=16'h1234, ir_valid a single pulse 3 cycles after the strobe.
REQ-037 imem_read and pc_inc in the same cycle at pc=5 -> imem_addr=5 for the whole fetch, pc=6.
REQ-038 jump=1 with jump_addr=8'h40 and pc_inc=1 together -> pc=8'h40; pc=8'hFF with pc_inc -> pc=0.
REQ-039 No ack for TIMEOUT=8 cycles -> fetch_err=1, ir unchanged, busy=0; next fetch acked with 16'hABCD -> fetch_err=0, ir=16'hABCD.
REQ-040 Reset asserted mid-WAIT, then an ack pulse after release -> all outputs at reset values, no ir_valid.
REQ-041 Second imem_read during WAIT -> ignored; exactly one ir_valid pulse results.
